// File: rtl/dualport_ram_be.sv
// True dual-port RAM with per-byte write enables, selectable read-during-write and a clear engine.
// Both ports and the clear engine run on one clock; the clear engine owns the array while init_busy=1.
module dualport_ram_be #(
    parameter int               width      = 16,
    parameter int               widthad    = 10,
    parameter int               byte_width = 8,
    parameter int               out_reg    = 0,
    parameter int               rdw_mode   = 0,
    parameter logic [width-1:0] init_value = '0
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           init_req,
    output logic                           init_busy,
    input  logic                           rden_a,
    input  logic                           wren_a,
    input  logic [width/byte_width-1:0]    byteena_a,
    input  logic [widthad-1:0]             address_a,
    input  logic [width-1:0]               data_a,
    output logic [width-1:0]               q_a,
    output logic                           valid_a,
    input  logic                           rden_b,
    input  logic                           wren_b,
    input  logic [width/byte_width-1:0]    byteena_b,
    input  logic [widthad-1:0]             address_b,
    input  logic [width-1:0]               data_b,
    output logic [width-1:0]               q_b,
    output logic                           valid_b
);
    // state | meaning
    // IDLE  | ports own the array
    // CLEAR | writing init_value to ram[cnt], one word per cycle; port traffic dropped
    localparam int nbytes = width / byte_width;
    localparam int depth  = 2 ** widthad;

    typedef enum logic {IDLE, CLEAR} clr_state_t;

    clr_state_t         state;
    logic [widthad-1:0] cnt;
    logic [width-1:0]   mem [depth];

    logic               acc_a, acc_b;
    logic [width-1:0]   rd_a, rd_b;
    logic [width-1:0]   s1_q_a, s1_q_b;
    logic               s1_v_a, s1_v_b;

    function automatic logic [width-1:0] merge(input logic [width-1:0]  old,
                                               input logic [width-1:0]  d,
                                               input logic [nbytes-1:0] be);
        merge = old;
        for (int i = 0; i < nbytes; i++)
            if (be[i]) merge[i*byte_width +: byte_width] = d[i*byte_width +: byte_width];
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= CLEAR;
            cnt       <= '0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state     <= IDLE;
                        init_busy <= 1'b0;
                    end
                end
                default: begin
                    if (init_req) begin
                        state     <= CLEAR;
                        cnt       <= '0;
                        init_busy <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Port A is applied last so it wins lanes enabled on both ports.
    always_ff @(posedge clock) begin
        if (init_busy) begin
            mem[cnt] <= init_value;
        end else begin
            for (int i = 0; i < nbytes; i++) begin
                if (wren_b && byteena_b[i])
                    mem[address_b][i*byte_width +: byte_width] <= data_b[i*byte_width +: byte_width];
                if (wren_a && byteena_a[i])
                    mem[address_a][i*byte_width +: byte_width] <= data_a[i*byte_width +: byte_width];
            end
        end
    end

    assign acc_a = rden_a && !init_busy;
    assign acc_b = rden_b && !init_busy;

    // Cross-port writes are never forwarded; only the port's own write can be.
    always_comb begin
        rd_a = mem[address_a];
        rd_b = mem[address_b];
        if (rdw_mode == 0 && wren_a) rd_a = merge(rd_a, data_a, byteena_a);
        if (rdw_mode == 0 && wren_b) rd_b = merge(rd_b, data_b, byteena_b);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_q_a <= '0;
            s1_q_b <= '0;
            s1_v_a <= 1'b0;
            s1_v_b <= 1'b0;
        end else begin
            s1_v_a <= acc_a;
            s1_v_b <= acc_b;
            if (acc_a) s1_q_a <= rd_a;
            if (acc_b) s1_q_b <= rd_b;
        end
    end

    generate
        if (out_reg != 0) begin : g_oreg
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    q_a     <= '0;
                    q_b     <= '0;
                    valid_a <= 1'b0;
                    valid_b <= 1'b0;
                end else begin
                    valid_a <= s1_v_a;
                    valid_b <= s1_v_b;
                    if (s1_v_a) q_a <= s1_q_a;
                    if (s1_v_b) q_b <= s1_q_b;
                end
            end
        end else begin : g_noreg
            assign q_a     = s1_q_a;
            assign q_b     = s1_q_b;
            assign valid_a = s1_v_a;
            assign valid_b = s1_v_b;
        end
    endgenerate
endmodule

// File: tb/tb_dualport_ram_be.sv
// Scoreboard bench: u0 = write-first, latency 1; u1 = read-first, latency 2; both see identical stimulus.
module tb_dualport_ram_be;
    localparam logic [15:0] init_v = 16'hC35A;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        init_req = 1'b0;
    logic        rden_a = 1'b0, wren_a = 1'b0, rden_b = 1'b0, wren_b = 1'b0;
    logic [1:0]  byteena_a = '0, byteena_b = '0;
    logic [3:0]  address_a = '0, address_b = '0;
    logic [15:0] data_a = '0, data_b = '0;

    logic        busy0, busy1;
    logic [15:0] q_a0, q_b0, q_a1, q_b1;
    logic        valid_a0, valid_b0, valid_a1, valid_b1;

    dualport_ram_be #(.width(16), .widthad(4), .byte_width(8), .out_reg(0), .rdw_mode(0), .init_value(init_v)) u0 (
        .clock(clock), .reset_n(reset_n), .init_req(init_req), .init_busy(busy0),
        .rden_a(rden_a), .wren_a(wren_a), .byteena_a(byteena_a), .address_a(address_a), .data_a(data_a),
        .q_a(q_a0), .valid_a(valid_a0),
        .rden_b(rden_b), .wren_b(wren_b), .byteena_b(byteena_b), .address_b(address_b), .data_b(data_b),
        .q_b(q_b0), .valid_b(valid_b0));

    dualport_ram_be #(.width(16), .widthad(4), .byte_width(8), .out_reg(1), .rdw_mode(1), .init_value(init_v)) u1 (
        .clock(clock), .reset_n(reset_n), .init_req(init_req), .init_busy(busy1),
        .rden_a(rden_a), .wren_a(wren_a), .byteena_a(byteena_a), .address_a(address_a), .data_a(data_a),
        .q_a(q_a1), .valid_a(valid_a1),
        .rden_b(rden_b), .wren_b(wren_b), .byteena_b(byteena_b), .address_b(address_b), .data_b(data_b),
        .q_b(q_b1), .valid_b(valid_b1));

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        int          when;
    } exp_t;

    exp_t        sb [4][$];      // 0:u0.A 1:u0.B 2:u1.A 3:u1.B
    logic [15:0] mdl [16];
    logic        drop = 1'b0;

    logic        vld [4];
    logic [15:0] qv  [4];
    assign vld[0] = valid_a0; assign vld[1] = valid_b0;
    assign vld[2] = valid_a1; assign vld[3] = valid_b1;
    assign qv[0]  = q_a0;     assign qv[1]  = q_b0;
    assign qv[2]  = q_a1;     assign qv[3]  = q_b1;

    function automatic logic [15:0] merge16(input logic [15:0] old, input logic [15:0] d, input logic [1:0] be);
        merge16 = old;
        if (be[0]) merge16[7:0]  = d[7:0];
        if (be[1]) merge16[15:8] = d[15:8];
    endfunction

    always @(negedge clock) begin
        for (int j = 0; j < 4; j++) begin
            if (vld[j]) begin
                if (sb[j].size() == 0) begin
                    chk($sformatf("spurious_valid%0d", j), 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb[j].pop_front();
                    chk($sformatf("rd_data%0d", j), 32'(qv[j]), 32'(e.data));
                    chk($sformatf("rd_latency%0d", j), 32'(cyc), 32'(e.when));
                end
            end else if (sb[j].size() != 0 && sb[j][0].when <= cyc) begin
                exp_t e;
                e = sb[j].pop_front();
                chk($sformatf("missing_valid%0d", j), 32'd0, 32'd1);
            end
        end
    end

    // Builds expectations from the current inputs, then advances one clock and clears requests.
    task automatic step();
        logic        rd, wr;
        logic [1:0]  be;
        logic [3:0]  ad;
        logic [15:0] d, old;
        if (!drop) begin
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < 2; p++) begin
                    rd = p ? rden_b : rden_a;
                    wr = p ? wren_b : wren_a;
                    be = p ? byteena_b : byteena_a;
                    ad = p ? address_b : address_a;
                    d  = p ? data_b : data_a;
                    old = mdl[ad];
                    if (rd) begin
                        exp_t e;
                        e.data = (k == 0 && wr) ? merge16(old, d, be) : old;
                        e.when = cyc + k + 1;
                        sb[k*2+p].push_back(e);
                    end
                end
            end
            if (wren_b) mdl[address_b] = merge16(mdl[address_b], data_b, byteena_b);
            if (wren_a) mdl[address_a] = merge16(mdl[address_a], data_a, byteena_a);
        end
        @(posedge clock); #1;
        rden_a = 1'b0; wren_a = 1'b0; rden_b = 1'b0; wren_b = 1'b0; init_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_clear(input string tag);
        int n = 0;
        while (busy0 && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'd16);
        chk({tag, "_busy1_low"}, 32'(busy1), 32'd0);
        for (int i = 0; i < 16; i++) mdl[i] = init_v;
    endtask

    task automatic wr_a(input logic [3:0] ad, input logic [15:0] d, input logic [1:0] be);
        wren_a = 1'b1; address_a = ad; data_a = d; byteena_a = be;
    endtask

    task automatic wr_b(input logic [3:0] ad, input logic [15:0] d, input logic [1:0] be);
        wren_b = 1'b1; address_b = ad; data_b = d; byteena_b = be;
    endtask

    task automatic rd_a(input logic [3:0] ad);
        rden_a = 1'b1; address_a = ad;
    endtask

    task automatic rd_b(input logic [3:0] ad);
        rden_b = 1'b1; address_b = ad;
    endtask

    logic [15:0] held [4];

    initial begin
        for (int i = 0; i < 16; i++) mdl[i] = 16'h0000;
        repeat (3) @(posedge clock);
        #1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("rst_q%0d", j), 32'(qv[j]), 32'd0);
            chk($sformatf("rst_valid%0d", j), 32'(vld[j]), 32'd0);
        end
        chk("rst_busy0", 32'(busy0), 32'd1);
        chk("rst_busy1", 32'(busy1), 32'd1);

        // Power-up clear, then read every word back.
        reset_n = 1'b1;
        wait_clear("powerup");
        for (int a = 0; a < 16; a++) begin
            rd_a(4'(a));
            step();
        end
        idle(3);

        // Full write on A, upper-lane write on B, read back.
        wr_a(4'd3, 16'h1234, 2'b11); step();
        wr_b(4'd3, 16'hAB00, 2'b10); step();
        rd_a(4'd3); step();
        idle(3);

        // Simultaneous writes to one word: lane overlap goes to A.
        wr_a(4'd5, 16'h1111, 2'b01); wr_b(4'd5, 16'h2222, 2'b11); step();
        rd_a(4'd5); step();
        wr_a(4'd5, 16'h1111, 2'b11); wr_b(4'd5, 16'h2222, 2'b11); step();
        rd_b(4'd5); step();
        wr_a(4'd5, 16'hFFFF, 2'b00); step();
        rd_a(4'd5); step();
        idle(3);

        // Same-port read-during-write, then plain read.
        wr_a(4'd7, 16'h00FF, 2'b11); step();
        rd_a(4'd7); wr_a(4'd7, 16'hAA00, 2'b10); step();
        rd_a(4'd7); step();
        idle(3);

        // Cross-port read sees old data.
        wr_a(4'd3, 16'h5555, 2'b11); rd_b(4'd3); step();
        rd_b(4'd3); step();
        idle(3);

        // Back-to-back reads on B.
        for (int a = 0; a < 4; a++) begin
            rd_b(4'(a));
            step();
        end
        idle(4);

        // Clear request alongside a read; traffic during the clear is lost, q holds.
        rd_a(4'd3); init_req = 1'b1; step();
        drop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_a(4'(i), 16'hDEAD, 2'b11); wr_b(4'(i + 8), 16'hBEEF, 2'b11);
            rd_a(4'(i)); rd_b(4'(i + 8));
            if (i == 2) for (int j = 0; j < 4; j++) held[j] = qv[j];
            step();
        end
        for (int j = 0; j < 4; j++) chk($sformatf("busy_q_hold%0d", j), 32'(qv[j]), 32'(held[j]));
        chk("busy_mid_clear", 32'(busy0), 32'd1);

        reset_n = 1'b0;
        #1;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("midrst_q%0d", j), 32'(qv[j]), 32'd0);
            chk($sformatf("midrst_valid%0d", j), 32'(vld[j]), 32'd0);
        end
        chk("midrst_busy", 32'(busy1), 32'd1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_n = 1'b1;
        drop = 1'b0;
        wait_clear("restart");
        for (int a = 0; a < 16; a++) begin
            rd_a(4'(a)); rd_b(4'(15 - a));
            step();
        end
        idle(3);

        // Random mixed traffic on both ports.
        for (int i = 0; i < 80; i++) begin
            rden_a = 1'($urandom_range(0, 1)); wren_a = 1'($urandom_range(0, 1));
            rden_b = 1'($urandom_range(0, 1)); wren_b = 1'($urandom_range(0, 1));
            address_a = 4'($urandom_range(0, 15)); address_b = 4'($urandom_range(0, 15));
            byteena_a = 2'($urandom_range(0, 3)); byteena_b = 2'($urandom_range(0, 3));
            data_a = 16'($urandom); data_b = 16'($urandom);
            step();
        end
        idle(4);

        for (int j = 0; j < 4; j++) chk($sformatf("sb_empty%0d", j), 32'(sb[j].size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dualport_ram_be.md
Name: dualport_ram_be

Overview:
Parametrised true dual-port RAM for the M92 video/sound memories, replacing fixed-word dual-port storage where per-byte writes and a known power-up state are needed.
- Adds per-byte write enables, selectable read-during-write behaviour and an optional output pipeline register.
- Adds a read-valid strobe per port and a hardware clear engine that fills the array with a constant after reset or on request.
- Both ports share one clock.

Parameters:
width, 16, data word width in bits; must be a multiple of byte_width
widthad, 10, address width; depth = 2**widthad
byte_width, 8, bits per byte-enable lane; nbytes = width/byte_width
out_reg, 0, 0 = read latency 1; 1 = extra output register, read latency 2
rdw_mode, 0, same-port read-during-write: 0 = new data (write-first), 1 = old data (read-first)
init_value, 0, width-bit word written to every location by the clear engine

Ports:
clock  in  1  single clock for both ports and the clear engine
reset_n  in  1  asynchronous active-low reset
init_req  in  1  one-cycle pulse: start a full clear (ignored while init_busy=1)
init_busy  out  1  high while the clear engine owns the array
rden_a  in  1  port A read request
wren_a  in  1  port A write request
byteena_a  in  nbytes  port A byte lane enables; lane i = data bits [i*byte_width +: byte_width]
address_a  in  widthad  port A address
data_a  in  width  port A write data
q_a  out  width  port A read data
valid_a  out  1  q_a holds data for a read issued latency cycles earlier
rden_b, wren_b, byteena_b, address_b, data_b, q_b, valid_b  same as port A, for port B

Behaviour:
Reset (reset_n=0, asynchronous):
- q_a = q_b = 0, valid_a = valid_b = 0, init_busy = 1, clear counter = 0.
- The array contents are not reset.
- On reset release the clear engine starts immediately.

Clear FSM:
- States are IDLE and CLEAR.
- In CLEAR, one word per cycle: ram[cnt] <= init_value, cnt increments.
- After writing address 2**widthad-1 it goes to IDLE and init_busy falls on the next edge. A clear takes exactly 2**widthad cycles.
- IDLE -> CLEAR on init_req=1, with cnt=0 and init_busy=1 from the next edge.
- reset_n asserted mid-clear: the clear restarts from 0.
- While init_busy=1, all port reads and writes are dropped: no array update, valid stays 0, q holds its last value.

Write (init_busy=0, wren_x=1):
- For each lane i with byteena_x[i]=1, ram[address_x] lane i <= data_x lane i.
- Lanes with byteena_x[i]=0 are unchanged.
- wren_x with byteena_x all zero is a no-op.

Read (init_busy=0, rden_x=1):
- Stage 1 captures ram[address_x] on the next edge.
- out_reg=0: q_x and valid_x update at that edge (latency 1).
- out_reg=1: they update one edge later (latency 2).
- valid_x is 1 for exactly one cycle per accepted read.
- q_x holds its value when no read is issued.

Same-port read and write in one cycle (rden_x=wren_x=1):
- rdw_mode=0: q_x = merged word (new lanes where byteena=1, old lanes elsewhere).
- rdw_mode=1: q_x = the word before the write.
- wren_x alone never produces valid_x; write-only cycles leave q_x unchanged.

Cross-port, same address, same cycle:
- Read on one port and write on the other: the read returns old data.
- Both ports write: lanes enabled on both take port A data; lanes enabled on one port only take that port's data.

Pipeline:
- Reads are fully pipelined: one read per port per cycle, back-to-back, with no bubbles.
- Reads issued in the last cycle of CLEAR are dropped (init_busy still 1).

Test Plan:
1. width=16, widthad=4, out_reg=0: release reset -> init_busy=1 for exactly 16 cycles, then 0. Reading every address then returns init_value with valid_a one cycle after each rden_a.
2. Write 0x1234 @3 via A (byteena=2'b11), then B writes 0xAB with byteena=2'b10 @3 -> A read @3 returns 0xAB34.
3. Both ports write @5 in the same cycle: A=0x1111 with byteena=2'b01, B=0x2222 with byteena=2'b11 -> the word reads 0x2211. Repeat with A byteena=2'b11 -> 0x1111.
4. rdw_mode=0 vs 1: ram[7]=0x00FF; A rden+wren @7 with data 0xAA00, byteena=2'b10 -> q_a=0xAAFF (mode 0) or 0x00FF (mode 1). A later read returns 0xAAFF in both modes.
5. out_reg=1: 4 back-to-back reads on B @0..3 -> valid_b high for 4 consecutive cycles starting 2 cycles after the first rden_b, with data in order.
6. init_req mid-traffic, then reset_n pulsed low at cycle 6 of the clear -> outputs zero immediately. The clear restarts and init_busy stays high for a further 16 cycles. Port writes during the clear are lost and all words read init_value.
